// File: rtl/seq101_pkg.sv
// Shared types and transition functions for the 101 non-overlapping detector.
package seq101_pkg;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } seq_state_t;

  function automatic seq_state_t seq_next(input seq_state_t s, input logic x);
    seq_state_t n;
    case (s)
      S0:      n = x ? S1 : S0;
      S1:      n = x ? S1 : S2;
      S2:      n = x ? S3 : S0;
      default: n = x ? S1 : S0;
    endcase
    return n;
  endfunction

  function automatic logic seq_out(input seq_state_t s);
    return (s == S3);
  endfunction

endpackage

// File: rtl/seq101_next_state.sv
// Shared combinational decoder: one detector step plus "entering S3" flag.
module seq101_next_state
  import seq101_pkg::*;
(
  input  seq_state_t state,
  input  logic       x,
  output seq_state_t next_state,
  output logic       z
);

  always_comb begin
    next_state = seq_next(state, x);
    z          = seq_out(next_state);
  end

endmodule

// File: rtl/seq101_channel_arbiter.sv
// Round-robin time-shares one 101 detector across NCH serial channels,
// keeping per-channel detector context and a saturating match total.
module seq101_channel_arbiter
  import seq101_pkg::*;
#(
  parameter  int unsigned NCH   = 4,
  parameter  int unsigned CNT_W = 8,
  localparam int unsigned IDX_W = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   bit_valid,
  input  logic [NCH-1:0]   bit_in,
  output logic [NCH-1:0]   bit_ready,
  input  logic [NCH-1:0]   clr_ctx,
  output logic             match_valid,
  output logic [IDX_W-1:0] match_chan,
  output logic [CNT_W-1:0] match_total
);

  seq_state_t       ctx [NCH];
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;
  logic [NCH-1:0]   eligible;
  seq_state_t       cur_state;
  seq_state_t       nxt_state;
  logic             cur_bit;
  logic             nxt_match;

  // A channel being cleared never consumes its bit that cycle.
  assign eligible = bit_valid & ~clr_ctx & {NCH{rst_n}};

  // First eligible channel searching upward from rr_ptr, wrapping at NCH.
  always_comb begin
    logic [IDX_W:0] pos;
    bit_ready = '0;
    gnt_idx   = '0;
    gnt_any   = 1'b0;
    pos       = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      pos = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (pos >= (IDX_W+1)'(NCH)) pos = pos - (IDX_W+1)'(NCH);
      if (!gnt_any && eligible[pos[IDX_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = pos[IDX_W-1:0];
      end
    end
    if (gnt_any) bit_ready[gnt_idx] = 1'b1;
  end

  assign cur_state = ctx[gnt_idx];
  assign cur_bit   = bit_in[gnt_idx];

  seq101_next_state u_dec (
    .state      (cur_state),
    .x          (cur_bit),
    .next_state (nxt_state),
    .z          (nxt_match)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NCH); i++) ctx[i] <= S0;
      rr_ptr      <= '0;
      match_valid <= 1'b0;
      match_chan  <= '0;
      match_total <= '0;
    end else begin
      for (int i = 0; i < int'(NCH); i++) begin
        if (clr_ctx[i])                              ctx[i] <= S0;
        else if (gnt_any && gnt_idx == IDX_W'(i))    ctx[i] <= nxt_state;
      end
      match_valid <= gnt_any & nxt_match;
      if (gnt_any) begin
        rr_ptr <= (gnt_idx == IDX_W'(NCH-1)) ? '0 : gnt_idx + IDX_W'(1);
        if (nxt_match) match_chan <= gnt_idx;
      end
      // Total moves together with the match pulse and sticks at all-ones.
      if (gnt_any && nxt_match && match_total != {CNT_W{1'b1}})
        match_total <= match_total + CNT_W'(1);
    end
  end

endmodule
